configx_psif: RTL
=================

Name: configx_psif

Overview:
Writable configuration register bank that PS software programs through a single address/data interface. It is the write-side counterpart of the statusx_psif status-read interface. It holds NUM_REGS registers of DATA_WIDTH bits and drives them flattened onto the accelerator datapath. It also issues a one-cycle update pulse per register, returns a registered write acknowledge and error flag, and provides registered read-back.

Parameters:
DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, PS address width.
BASE_ADDR, 32'h00000000, word address of register 0.
ADDR_RANGE_WIDTH, 4, decode window: the block owns addresses whose bits [ADDR_WIDTH-1:ADDR_RANGE_WIDTH] equal the same bits of BASE_ADDR.
NUM_REGS, 1, number of registers; must be 1 .. 2^ADDR_RANGE_WIDTH.
RST_VALUE, 0, flattened reset image, NUM_REGS*DATA_WIDTH bits; register i resets to slice [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
NO_REG_CODE, 32'hcafecafe, read data returned for an in-window address with no register behind it.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
ps_addr  input  ADDR_WIDTH  word address, shared by read and write.
ps_wren  input  1  write request, one cycle per write.
ps_wdat  input  DATA_WIDTH  write data.
ps_wstb  input  DATA_WIDTH/8  byte enables; bit k enables byte k.
ps_wvld  output  1  write acknowledge pulse.
ps_werr  output  1  write error; valid only when ps_wvld=1.
ps_rden  input  1  read request, one cycle per read.
ps_rdat  output  DATA_WIDTH  read data.
ps_rvld  output  1  read data valid pulse.
odat  output  DATA_WIDTH*NUM_REGS  all registers flattened; register i sits at slice i.
oupd  output  NUM_REGS  bit i pulses for one cycle when register i changes value by write.

Behaviour:
- Decode:
  - local_addr = ps_addr - BASE_ADDR, computed modulo 2^ADDR_WIDTH.
  - win = upper bits of ps_addr match the upper bits of BASE_ADDR, as defined by ADDR_RANGE_WIDTH.
  - hit = win & (local_addr < NUM_REGS).
- Reset (rst=1 at a clock edge):
  - Register i loads its RST_VALUE slice.
  - ps_wvld, ps_werr, ps_rvld, oupd = 0; ps_rdat = 0.
  - Any request presented in the same cycle as reset is dropped with no response.
- Write (ps_wren=1, win=1):
  - If hit: at the edge, each byte k of reg[local_addr] with ps_wstb[k]=1 takes ps_wdat byte k; other bytes hold.
  - Next cycle: ps_wvld=1 and ps_werr = ~hit.
  - If ~hit: no register changes.
- Update pulse:
  - oupd[local_addr] = 1 in the cycle the new odat value appears, i.e. 1 cycle after ps_wren, coincident with ps_wvld.
  - It fires only if the new value differs from the old value.
  - ps_wstb=0 gives ps_wvld=1, ps_werr=0, no pulse.
- Write outside the window (win=0): the block does not respond; ps_wvld stays 0 and a different slave answers.
- Read (ps_rden=1):
  - Latency is 1 cycle: ps_rvld = registered (ps_rden & win).
  - ps_rdat = registered value: reg[local_addr] if hit; NO_REG_CODE (truncated/zero-extended to DATA_WIDTH) if win & ~hit; 0 when ps_rvld=0.
- Simultaneous read and write to the same register: both execute; read returns the pre-write value and odat shows the new value.
- Back-to-back requests every cycle are legal at full throughput; no backpressure, no ready signal.
- odat is a direct register output with no combinational path from PS inputs.

Test Plan:
- Reset with RST_VALUE={32'h0000_0010, 32'hDEAD_BEEF}, NUM_REGS=2 -> after reset odat matches exactly; ps_wvld/ps_rvld/oupd = 0; read addr 1 returns 32'h0000_0010 with ps_rvld one cycle later.
- Full write: BASE_ADDR=32'h40, write 32'h1234_5678 to addr 32'h41 with ps_wstb=4'hF -> next cycle odat[63:32]=32'h1234_5678, oupd=2'b10, ps_wvld=1, ps_werr=0; register 0 unchanged.
- Byte strobe: reg0=32'hAABB_CCDD, write 32'h1122_3344 with ps_wstb=4'b0101 -> reg0=32'hAA22_CC44, oupd[0]=1. Repeating the same write -> ps_wvld=1, oupd=0.
- Error/window: write to 32'h45 (in window, no register) -> ps_wvld=1, ps_werr=1, no register change; read 32'h45 -> ps_rdat=32'hcafecafe. Write or read to 32'h80 -> no ps_wvld or ps_rvld.
- Same-cycle read+write to addr 32'h40: old value 32'h1, write 32'h2 -> ps_rdat=32'h1, odat[31:0]=32'h2, both valids high in the same cycle.
- Reset mid-stream: ps_wren=1 in the same cycle as rst=1 -> no ack, register equals its RST_VALUE slice. A write in the first cycle after rst=0 is accepted normally.

Source files
------------

// File: rtl/configx_psif_if.sv
// PS-side address/data bus of the configuration bank: shared address,
// write request with byte strobes and registered ack/error, read request with registered data.
interface configx_psif_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   ps_addr;
  logic                    ps_wren;
  logic [DATA_WIDTH-1:0]   ps_wdat;
  logic [DATA_WIDTH/8-1:0] ps_wstb;
  logic                    ps_wvld;
  logic                    ps_werr;
  logic                    ps_rden;
  logic [DATA_WIDTH-1:0]   ps_rdat;
  logic                    ps_rvld;

  modport master (
    output ps_addr, ps_wren, ps_wdat, ps_wstb, ps_rden,
    input  ps_wvld, ps_werr, ps_rdat, ps_rvld
  );
  modport slave (
    input  ps_addr, ps_wren, ps_wdat, ps_wstb, ps_rden,
    output ps_wvld, ps_werr, ps_rdat, ps_rvld
  );
endinterface

// File: rtl/configx_psif.sv
// Writable configuration register bank: byte-strobed PS writes, per-register
// change pulses, registered write ack/error and 1-cycle registered read-back.
module configx_psif #(
  parameter int                              DATA_WIDTH       = 32,
  parameter int                              ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0]           BASE_ADDR        = '0,
  parameter int                              ADDR_RANGE_WIDTH = 4,
  parameter int                              NUM_REGS         = 1,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RST_VALUE        = '0,
  parameter logic [31:0]                     NO_REG_CODE      = 32'hcafecafe
) (
  input  logic                            clk,
  input  logic                            rst,
  configx_psif_if.slave                   ps,
  output logic [DATA_WIDTH*NUM_REGS-1:0]  odat,
  output logic [NUM_REGS-1:0]             oupd
);
  localparam int NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] local_addr;
  logic                  win, hit;

  assign local_addr = ps.ps_addr - BASE_ADDR;
  assign win = (ps.ps_addr[ADDR_WIDTH-1:ADDR_RANGE_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:ADDR_RANGE_WIDTH]);
  assign hit = win && (local_addr < ADDR_WIDTH'(NUM_REGS));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic                  wr;
    logic [DATA_WIDTH-1:0] reg_q, reg_d;
    logic                  upd_q;

    assign wr = ps.ps_wren && hit && (local_addr == ADDR_WIDTH'(i));

    always_comb begin
      reg_d = reg_q;
      for (int b = 0; b < NB; b++)
        if (ps.ps_wstb[b]) reg_d[b*8 +: 8] = ps.ps_wdat[b*8 +: 8];
    end

    // Pulse only on a real value change, so an idempotent rewrite is silent
    always_ff @(posedge clk) begin
      if (rst) begin
        reg_q <= RST_VALUE[DATA_WIDTH*i +: DATA_WIDTH];
        upd_q <= 1'b0;
      end else begin
        if (wr) reg_q <= reg_d;
        upd_q <= wr && (reg_d != reg_q);
      end
    end

    assign odat[DATA_WIDTH*i +: DATA_WIDTH] = reg_q;
    assign oupd[i] = upd_q;
  end

  logic [DATA_WIDTH-1:0] rd_sel, rdat_d, rdat_q;
  logic                  wvld_q, werr_q, rvld_q;

  // Read mux sees pre-write register values, so a same-cycle read+write returns old data
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (local_addr == ADDR_WIDTH'(i)) rd_sel = odat[DATA_WIDTH*i +: DATA_WIDTH];
    rdat_d = '0;
    if (ps.ps_rden && win) rdat_d = hit ? rd_sel : DATA_WIDTH'(NO_REG_CODE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wvld_q <= 1'b0;
      werr_q <= 1'b0;
      rvld_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      wvld_q <= ps.ps_wren && win;
      werr_q <= ps.ps_wren && win && !hit;
      rvld_q <= ps.ps_rden && win;
      rdat_q <= rdat_d;
    end
  end

  assign ps.ps_wvld = wvld_q;
  assign ps.ps_werr = werr_q;
  assign ps.ps_rvld = rvld_q;
  assign ps.ps_rdat = rdat_q;
endmodule
